// File: rtl/seg7_scan_driver_if.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_driver_if
// Brief    : Load bus carrying BCD digits and decimal-point mask into the
//            seven-segment scan driver.
// Revision : 1.0 - initial release
// ============================================================================
interface seg7_scan_driver_if;
  logic       load;
  logic [3:0] thos;
  logic [3:0] huns;
  logic [3:0] tens;
  logic [3:0] ones;
  logic [3:0] dp_mask;

  // Upstream BCD source drives the bus
  modport master (
    output load,
    output thos,
    output huns,
    output tens,
    output ones,
    output dp_mask
  );

  // Scan driver samples the bus
  modport slave (
    input load,
    input thos,
    input huns,
    input tens,
    input ones,
    input dp_mask
  );
endinterface
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_driver
// Brief    : Four-digit time-multiplexed common-anode seven-segment driver.
//            Digits are captured into a shadow register on a load strobe and
//            scanned thousands -> ones, each slot opening with an all-off
//            blanking gap to suppress ghosting. All outputs are registered.
// Options  : SEG_LZ_BLANK_EN - when defined, leading zeros are blanked
//            during DRIVE (ones digit is never blanked).
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_driver #(
  parameter int SCAN_DIV  = 100000,  // cycles per digit slot, >= 4
  parameter int BLANK_CYC = 1000     // blank cycles per slot, 1 .. SCAN_DIV-2
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  seg7_scan_driver_if.slave      bcd,
  output logic [3:0]             an,
  output logic [6:0]             seg,
  output logic                   dp,
  output logic                   slot_done
);

  localparam int                PCNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(SCAN_DIV - 1);
  localparam logic [PCNT_W-1:0] PCNT_DRV  = PCNT_W'(BLANK_CYC);
  localparam logic [6:0]        SEG_OFF   = 7'h7F;
  localparam logic [6:0]        SEG_DASH  = 7'h3F;

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  state_t            state;
  logic [PCNT_W-1:0] pcnt;
  logic [1:0]        idx;

  logic [3:0] sh_thos;
  logic [3:0] sh_huns;
  logic [3:0] sh_tens;
  logic [3:0] sh_ones;
  logic [3:0] sh_dp_mask;

  logic [3:0] digit_sel;
  logic       dp_sel;
  logic       lz_blank;
  logic [6:0] seg_drive;
  logic [3:0] an_drive;

  // Active-low decode; non-BCD codes show a dash so a bad upstream value is
  // visible rather than silently mimicking a real digit.
  function automatic logic [6:0] seg7_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

  // Shadow register: last sampled value wins while load is held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_thos    <= 4'h0;
      sh_huns    <= 4'h0;
      sh_tens    <= 4'h0;
      sh_ones    <= 4'h0;
      sh_dp_mask <= 4'h0;
    end else if (bcd.load) begin
      sh_thos    <= bcd.thos;
      sh_huns    <= bcd.huns;
      sh_tens    <= bcd.tens;
      sh_ones    <= bcd.ones;
      sh_dp_mask <= bcd.dp_mask;
    end
  end

  // Select the shadow digit and decimal point for the current slot
  always_comb begin
    digit_sel = sh_ones;
    case (idx)
      2'd3:    digit_sel = sh_thos;
      2'd2:    digit_sel = sh_huns;
      2'd1:    digit_sel = sh_tens;
      default: digit_sel = sh_ones;
    endcase
    dp_sel = sh_dp_mask[idx];
  end

`ifdef SEG_LZ_BLANK_EN
  // Leading-zero suppression: a digit blanks only if it and every more
  // significant digit are zero; the ones digit always shows.
  always_comb begin
    lz_blank = 1'b0;
    case (idx)
      2'd3:    lz_blank = (sh_thos == 4'h0);
      2'd2:    lz_blank = (sh_thos == 4'h0) && (sh_huns == 4'h0);
      2'd1:    lz_blank = (sh_thos == 4'h0) && (sh_huns == 4'h0) &&
                          (sh_tens == 4'h0);
      default: lz_blank = 1'b0;
    endcase
  end
`else
  // Without suppression every digit is always decoded
  assign lz_blank = 1'b0;
`endif

  // Drive-phase output values; anode timing is independent of blanking
  always_comb begin
    seg_drive = lz_blank ? SEG_OFF : seg7_decode(digit_sel);
    an_drive  = ~(4'b0001 << idx);
  end

  // Prescaler, slot index, blank/drive FSM and registered display outputs.
  // Outputs reflect the state of the previous cycle, so a change of shadow
  // data or FSM state becomes visible one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt      <= '0;
      idx       <= 2'd3;
      state     <= ST_BLANK;
      an        <= 4'hF;
      seg       <= SEG_OFF;
      dp        <= 1'b1;
      slot_done <= 1'b0;
    end else begin
      // Registered outputs from the current state
      case (state)
        ST_DRIVE: begin
          an  <= an_drive;
          seg <= seg_drive;
          dp  <= ~dp_sel;
        end
        default: begin
          an  <= 4'hF;
          seg <= SEG_OFF;
          dp  <= 1'b1;
        end
      endcase
      slot_done <= (idx == 2'd0) && (pcnt == PCNT_LAST);

      // Prescaler wrap ends the slot and steps 3 -> 2 -> 1 -> 0 -> 3
      if (pcnt == PCNT_LAST) begin
        pcnt <= '0;
        idx  <= idx - 2'd1;
      end else begin
        pcnt <= pcnt + 1'b1;
      end

      // Next state tracks where pcnt is going
      case (state)
        ST_BLANK: begin
          if ((pcnt != PCNT_LAST) && ((pcnt + 1'b1) == PCNT_DRV)) begin
            state <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (pcnt == PCNT_LAST) begin
            state <= ST_BLANK;
          end
        end
        default: state <= ST_BLANK;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan_driver
// Brief    : Self-checking bench for seg7_scan_driver. Two instances share one
//            load bus: A (SCAN_DIV=8, BLANK_CYC=2) and B (SCAN_DIV=4,
//            BLANK_CYC=2). Expected outputs come from an arithmetic model of
//            the display timeline. Honors SEG_LZ_BLANK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

  logic clk;
  logic rst_n;

  seg7_scan_driver_if bus ();

  logic [3:0] an_a, an_b;
  logic [6:0] seg_a, seg_b;
  logic       dp_a, dp_b;
  logic       sd_a, sd_b;

  seg7_scan_driver #(.SCAN_DIV(8), .BLANK_CYC(2)) u_dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .bcd       (bus),
    .an        (an_a),
    .seg       (seg_a),
    .dp        (dp_a),
    .slot_done (sd_a)
  );

  seg7_scan_driver #(.SCAN_DIV(4), .BLANK_CYC(2)) u_dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .bcd       (bus),
    .an        (an_b),
    .seg       (seg_b),
    .dp        (dp_b),
    .slot_done (sd_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_fail = 0;
  int          k      = 0;      // edges since reset release
  logic [19:0] sh     = '0;     // model shadow {thos,huns,tens,ones,mask}

  localparam logic [12:0] RST_OUT = {4'hF, 7'h7F, 1'b1, 1'b0};

  // Single comparison point
  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] ref_seg(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  // Display output {an,seg,dp,slot_done} produced from the situation
  // kk edges after reset with shadow contents s.
  function automatic logic [12:0] model_out(input int sd, input int bc,
                                            input int kk,
                                            input logic [19:0] s);
    int         pc;
    int         slot;
    logic [3:0] d [4];
    logic [3:0] an_e;
    logic [6:0] seg_e;
    logic       done_e;
    logic       blank;
    pc     = kk % sd;
    slot   = 3 - ((kk / sd) % 4);
    done_e = (slot == 0) && (pc == sd - 1);
    if (pc < bc) return {4'hF, 7'h7F, 1'b1, done_e};
    d[3] = s[19:16];
    d[2] = s[15:12];
    d[1] = s[11:8];
    d[0] = s[7:4];
    an_e = 4'hF;
    an_e[slot] = 1'b0;
    seg_e = ref_seg(d[slot]);
`ifdef SEG_LZ_BLANK_EN
    blank = (slot != 0);
    for (int j = 3; j >= slot; j--) begin
      if (d[j] != 4'h0) blank = 1'b0;
    end
    if (blank) seg_e = 7'h7F;
`else
    blank = 1'b0;
    if (blank) seg_e = 7'h7F;
`endif
    return {an_e, seg_e, ~s[slot], done_e};
  endfunction

  // Advance one clock: predict, update model shadow, check both DUTs
  task automatic step();
    logic [12:0] exp_a;
    logic [12:0] exp_b;
    exp_a = model_out(8, 2, k, sh);
    exp_b = model_out(4, 2, k, sh);
    if (bus.load) sh = {bus.thos, bus.huns, bus.tens, bus.ones, bus.dp_mask};
    k++;
    @(negedge clk);
    chk($sformatf("a_k%0d", k), {an_a, seg_a, dp_a, sd_a}, exp_a);
    chk($sformatf("b_k%0d", k), {an_b, seg_b, dp_b, sd_b}, exp_b);
  endtask

  task automatic set_bus(input logic ld, input logic [3:0] t, h, te, o, m);
    bus.load    = ld;
    bus.thos    = t;
    bus.huns    = h;
    bus.tens    = te;
    bus.ones    = o;
    bus.dp_mask = m;
  endtask

  initial begin
    rst_n = 1'b0;
    set_bus(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_a", {an_a, seg_a, dp_a, sd_a}, RST_OUT);
    chk("rst_b", {an_b, seg_b, dp_b, sd_b}, RST_OUT);
    rst_n = 1'b1;
    k  = 0;
    sh = '0;

    // Scan order with digits 1,2,5,0 and dp on hundreds
    set_bus(1'b1, 4'd1, 4'd2, 4'd5, 4'd0, 4'b0100);
    step();
    bus.load = 1'b0;
    for (int i = 0; i < 70; i++) step();

    // Mid-slot update of ones at pcnt=4 of A's ones slot
    while (!((k % 8 == 4) && ((k / 8) % 4 == 3))) step();
    bus.ones = 4'd9;
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    for (int i = 0; i < 4; i++) step();

    // Asynchronous reset in the middle of a drive phase
    while (k % 8 != 5) step();
    rst_n = 1'b0;
    #1;
    chk("arst_a", {an_a, seg_a, dp_a, sd_a}, RST_OUT);
    chk("arst_b", {an_b, seg_b, dp_b, sd_b}, RST_OUT);
    @(negedge clk);
    rst_n = 1'b1;
    k  = 0;
    sh = '0;
    for (int i = 0; i < 36; i++) step();

    // Invalid BCD on thousands, then leading-zero pattern 0007
    set_bus(1'b1, 4'hC, 4'd3, 4'd4, 4'd8, 4'b1001);
    step();
    bus.load = 1'b0;
    for (int i = 0; i < 34; i++) step();
    set_bus(1'b1, 4'd0, 4'd0, 4'd0, 4'd7, 4'b0000);
    step();
    bus.load = 1'b0;
    for (int i = 0; i < 34; i++) step();

    // Load held several cycles with changing values
    set_bus(1'b1, 4'd6, 4'd6, 4'd6, 4'd6, 4'b1111);
    step();
    set_bus(1'b1, 4'd0, 4'd4, 4'd0, 4'd2, 4'b0010);
    step();
    set_bus(1'b1, 4'd0, 4'd0, 4'd8, 4'd3, 4'b0001);
    step();
    bus.load = 1'b0;
    for (int i = 0; i < 34; i++) step();

    // Load coinciding with B's slot wrap
    for (int r = 0; r < 4; r++) begin
      while (k % 4 != 3) step();
      set_bus(1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              4'($urandom_range(0, 15)));
      step();
      bus.load = 1'b0;
      for (int i = 0; i < 5; i++) step();
    end

    // Randomized traffic with leading-zero bias
    for (int i = 0; i < 600; i++) begin
      bus.load    = ($urandom_range(0, 7) == 0);
      bus.thos    = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      bus.huns    = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      bus.tens    = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      bus.ones    = 4'($urandom_range(0, 15));
      bus.dp_mask = 4'($urandom_range(0, 15));
      step();
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
